// File: rtl/f_fetch_queue.sv
// Instruction prefetch queue between fetch and decode.
// Holds {pc, instr} pairs and hands the oldest one to decode, in program order.
// Applies backpressure to fetch when full. A redirect flush empties the queue.
module f_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 64;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // Status and handshakes derive only from registered occupancy
  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_empty = (r_count == '0);
    w_push  = in_valid && !w_full;
    w_pop   = out_ready && !w_empty;
  end

  // Entry storage; contents are left stale on flush/reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= {in_pc, in_instr};
    end
  end

  // Pointers and occupancy; flush overrides any concurrent push or pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Head read, substituting reset PC and a nop while empty
  always_comb begin
    w_head    = r_mem[r_rd_ptr];
    in_ready  = !w_full;
    out_valid = !w_empty;
    count     = r_count;
    if (w_empty) begin
      out_pc    = RESET_PC;
      out_instr = 32'h0000_0000;
    end else begin
      out_pc    = w_head[63:32];
      out_instr = w_head[31:0];
    end
  end

endmodule

// File: tb/tb_f_fetch_queue.sv
// Directed bench for f_fetch_queue with DEPTH = 4.
module tb_f_fetch_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int n_cmp;
  int n_err;

  f_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_count"},     32'(count),     32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_pc"},    out_pc,         32'h0000_3000);
    chk({tag, "_out_instr"}, out_instr,      32'h0000_0000);
  endtask

  initial begin
    logic [31:0] p;
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    chk_empty("por");
    tick();
    reset = 1'b0;

    // In-order flow: three pushes held, then drained
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h2401_0001; tick();
    in_pc = 32'h3004; in_instr = 32'h2402_0002; tick();
    in_pc = 32'h3008; in_instr = 32'h0022_1821; tick();
    in_valid = 1'b0;
    chk("flow_count3", 32'(count), 32'd3);
    chk("flow_head0_pc", out_pc, 32'h3000);
    chk("flow_head0_instr", out_instr, 32'h2401_0001);
    out_ready = 1'b1;
    tick();
    chk("flow_head1_pc", out_pc, 32'h3004);
    chk("flow_head1_instr", out_instr, 32'h2402_0002);
    tick();
    chk("flow_head2_pc", out_pc, 32'h3008);
    chk("flow_head2_instr", out_instr, 32'h0022_1821);
    tick();
    out_ready = 1'b0;
    chk_empty("flow_drained");

    // Fill to DEPTH, try a fifth push, then pop one
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h3010 + 32'(4 * i); in_instr = 32'h100 + 32'(i); tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_pc = 32'h3020; in_instr = 32'hBAD0_BAD0; tick();
    in_valid = 1'b0;
    chk("full_5th_ignored", 32'(count), 32'd4);
    chk("full_head", out_pc, 32'h3010);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pop1_in_ready", 32'(in_ready), 32'd1);
    chk("pop1_count", 32'(count), 32'd3);
    chk("pop1_head", out_pc, 32'h3014);
    chk("pop1_head_instr", out_instr, 32'h101);

    // Reset asserted mid-cycle with three entries held
    #2;
    reset = 1'b1;
    #1;
    chk_empty("midrst");
    #2;
    reset = 1'b0;
    tick();
    chk_empty("midrst_after");

    // Steady push+pop at count 2; pointers wrap several times
    in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      p = 32'h3040 + 32'(4 * j); in_pc = p; in_instr = p ^ 32'hA5A5_0000; tick();
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      p = 32'h3040 + 32'(4 * (k + 1)); in_pc = p; in_instr = p ^ 32'hA5A5_0000; tick();
      chk($sformatf("pp%0d_count", k), 32'(count), 32'd2);
      chk($sformatf("pp%0d_head", k), out_pc, 32'h3040 + 32'(4 * k));
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pp_head_instr", out_instr, 32'h3068 ^ 32'hA5A5_0000);

    // Bring to count 3, then flush together with a push
    in_valid = 1'b1; in_pc = 32'h3070; in_instr = 32'h7; tick();
    chk("preflush_count", 32'(count), 32'd3);
    flush = 1'b1; in_pc = 32'h30F0; in_instr = 32'hF0; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_empty("flush");
    in_valid = 1'b1; in_pc = 32'h3080; in_instr = 32'h0000_DEAD; tick();
    in_valid = 1'b0;
    chk("redirect_valid", 32'(out_valid), 32'd1);
    chk("redirect_pc", out_pc, 32'h3080);
    chk("redirect_instr", out_instr, 32'h0000_DEAD);
    chk("redirect_count", 32'(count), 32'd1);
    out_ready = 1'b1; tick();
    chk_empty("redirect_drain");

    // Empty pass-through with decode always ready
    in_valid = 1'b1; in_pc = 32'h3100; in_instr = 32'h1234_5678; tick();
    in_valid = 1'b0;
    chk("pass_valid", 32'(out_valid), 32'd1);
    chk("pass_pc", out_pc, 32'h3100);
    chk("pass_count", 32'(count), 32'd1);
    tick();
    out_ready = 1'b0;
    chk_empty("pass_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/f_fetch_queue.md
# f_fetch_queue

Instruction prefetch queue between the fetch stage (PC register plus instruction ROM) and the decode stage of the pipelined MIPS core. Each cycle it captures the `{pc, instr}` pair produced by fetch and presents the oldest captured pair to decode in program order. It decouples fetch from decode stalls. It provides backpressure so fetch holds its PC when the queue is full. A redirect flush discards every queued instruction.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; a power of two, at least 2.
- `RESET_PC`, 32'h00003000: value driven on `out_pc` while the queue is empty.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  fetch presents a valid pair this cycle.
- `in_pc`  in  32  PC of the fetched instruction.
- `in_instr`  in  32  fetched instruction word.
- `in_ready`  out  1  queue accepts a push; equals `!full`.
- `out_valid`  out  1  the head entry is valid; equals `!empty`.
- `out_pc`  out  32  PC of the head entry; `RESET_PC` when empty.
- `out_instr`  out  32  instruction of the head entry; 32'h00000000 (nop) when empty.
- `out_ready`  in  1  decode consumes the head this cycle (decode not stalled).
- `flush`  in  1  redirect; discards all entries.
- `count`  out  $clog2(DEPTH)+1  number of valid entries, from 0 to DEPTH.

## Operation
- Storage: DEPTH entries of 64 bits (`{pc, instr}`), a write pointer and a read pointer of $clog2(DEPTH) bits each, and `count`.
- Pointers wrap modulo DEPTH with no special case; `full` = (`count` == DEPTH) and `empty` = (`count` == 0).
- Push = `in_valid && in_ready`: the entry at the write pointer is written and the write pointer increments.
- Pop = `out_valid && out_ready`: the read pointer increments.
- `count` update: push only adds 1; pop only subtracts 1; push and pop together leave it unchanged.
- When full, `in_ready` = 0, so no push occurs that cycle even if a pop does. A freed slot becomes visible through `in_ready` in the following cycle.
- Pop from empty or push into full never happens, because the handshake gating prevents it; `count` never leaves the range 0..DEPTH.
- Output path: `out_pc`/`out_instr` are a combinational read of the head entry, muxed to `RESET_PC`/0 when empty. No combinational path exists from `in_*` to `out_*`.
- Flush has priority over push and pop in the same cycle. At the edge it sets both pointers and `count` to 0, and the concurrent push is dropped. Storage contents need not be cleared.
- Reset, asserted at any time including mid-operation, immediately forces pointers and `count` to 0. Consequently `out_valid` = 0, `in_ready` = 1, `out_pc` = `RESET_PC`, `out_instr` = 0 and `count` = 0 while reset is high and after it falls.

## Timing
- Latency: a pair pushed at edge N appears at the output after edge N when the queue was empty, and can be popped at edge N+1. Minimum fall-through is one cycle.
- Throughput: one push and one pop per cycle in steady state when the queue is neither empty nor full.
- `in_ready` and `out_valid` depend only on registered state, so neither has a combinational dependence on `in_valid`, `out_ready` or `flush`.
- After a flush at edge N the queue is empty, and the first post-redirect pair can be pushed at edge N+1.
- Deassertion of reset is sampled on the clock; the first push is possible at the first rising edge with reset low.

## Test plan
- Reset: assert `reset` mid-cycle with 3 entries held -> immediately `count` = 0, `out_valid` = 0, `in_ready` = 1, `out_pc` = 32'h00003000, `out_instr` = 0.
- In-order flow: push (0x3000, 0x24010001), (0x3004, 0x24020002), (0x3008, 0x00221821) with `out_ready` = 0, then raise `out_ready` -> outputs in push order on three consecutive cycles, then `out_valid` = 0.
- Full/backpressure: push 4 pairs with DEPTH = 4 and `out_ready` = 0 -> `count` = 4 and `in_ready` = 0; a 5th `in_valid` is ignored. Pop one -> `in_ready` = 1 next cycle and `count` = 3.
- Simultaneous push and pop with `count` = 2 over 10 cycles -> `count` stays 2, order is preserved, and the pointers wrap past index 3 correctly.
- Flush plus push in the same cycle with `count` = 3 -> next cycle `count` = 0 and `out_valid` = 0. A push of (0x3080, x) the cycle after -> the head shows 0x3080.
- Empty pass-through: push at edge N with `out_ready` held at 1 -> `out_valid` = 1 after edge N, pop at edge N+1, `count` returns to 0.
